// File: rtl/alu_ctrl_md.sv
// ALU control decoder with an iterative shift-add HI/LO multiplier (mult/multu)
// and mfhi/mflo read port; stalls upstream while a multiply is in flight.
module alu_ctrl_md #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              kill_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] rs_i,
    input  logic [DATA_W-1:0] rt_i,
    output logic [2:0]        ALUCtrl_o,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] md_res_o,
    output logic              md_res_valid_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   mplier;
    logic [2*DATA_W-1:0] mcand;
    logic [2*DATA_W-1:0] acc;
    logic                neg;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;

    logic                is_r;
    logic                is_mul;
    logic                is_signed;
    logic                issue;
    logic                last;
    logic [DATA_W-1:0]   rs_mag;
    logic [DATA_W-1:0]   rt_mag;
    logic [2*DATA_W-1:0] acc_step;
    logic [2*DATA_W-1:0] prod;

    assign is_r      = (ALUOp_i == 2'b10);
    assign is_signed = is_r && (funct_i == F_MULT);
    assign is_mul    = is_r && ((funct_i == F_MULT) || (funct_i == F_MULTU));
    assign issue     = (state == S_IDLE) && valid_i && is_mul && !kill_i;
    assign last      = (cnt == CNT_W'(DATA_W - 1));

    // Magnitudes stay DATA_W wide unsigned, so the most-negative value maps to itself correctly.
    assign rs_mag = (is_signed && rs_i[DATA_W-1]) ? (~rs_i + 1'b1) : rs_i;
    assign rt_mag = (is_signed && rt_i[DATA_W-1]) ? (~rt_i + 1'b1) : rt_i;

    assign acc_step = acc + (mplier[0] ? mcand : '0);
    assign prod     = neg ? (~acc_step + 1'b1) : acc_step;

    always_comb begin
        ALUCtrl_o = 3'b010;
        case (ALUOp_i)
            2'b00: ALUCtrl_o = 3'b010;
            2'b01: ALUCtrl_o = 3'b110;
            2'b10: begin
                case (funct_i)
                    F_ADD:          ALUCtrl_o = 3'b010;
                    F_SUB:          ALUCtrl_o = 3'b110;
                    F_AND:          ALUCtrl_o = 3'b000;
                    F_OR:           ALUCtrl_o = 3'b001;
                    F_SLT:          ALUCtrl_o = 3'b111;
                    F_MULT, F_MULTU: ALUCtrl_o = 3'b011;
                    default:        ALUCtrl_o = 3'b010;
                endcase
            end
            default: ALUCtrl_o = 3'b010;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mplier <= '0;
            mcand  <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (kill_i) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        mcand  <= {{DATA_W{1'b0}}, rs_mag};
                        mplier <= rt_mag;
                        neg    <= is_signed && (rs_i[DATA_W-1] ^ rt_i[DATA_W-1]);
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        {hi, lo} <= prod;
                        state    <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // DONE is a read window too, so mfhi/mflo there see the freshly committed HI/LO.
    always_comb begin
        stall_o        = !rst_i && !kill_i && (issue || (state == S_BUSY));
        done_o         = !rst_i && !kill_i && (state == S_DONE);
        md_res_o       = '0;
        md_res_valid_o = 1'b0;
        if (!rst_i && valid_i && is_r && ((state == S_IDLE) || (state == S_DONE))) begin
            if (funct_i == F_MFHI) begin
                md_res_o       = hi;
                md_res_valid_o = 1'b1;
            end else if (funct_i == F_MFLO) begin
                md_res_o       = lo;
                md_res_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Self-checking bench for alu_ctrl_md: latency-based behavioural model compared
// every cycle, plus directed literal checks of the documented multiply cases.
module tb_alu_ctrl_md;
    localparam int W = 32;
    localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001;
    localparam logic [5:0] MFHI = 6'b010000, MFLO = 6'b010010;

    logic         clk = 1'b0;
    logic         rst, valid, kill;
    logic [1:0]   aluop;
    logic [5:0]   funct;
    logic [W-1:0] rs, rt;
    logic [2:0]   alu_ctrl;
    logic         stall, done, md_valid;
    logic [W-1:0] md_res;

    int n_chk = 0;
    int n_pass = 0;

    alu_ctrl_md #(.DATA_W(W)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .kill_i(kill),
        .ALUOp_i(aluop), .funct_i(funct), .rs_i(rs), .rt_i(rt),
        .ALUCtrl_o(alu_ctrl), .stall_o(stall), .done_o(done),
        .md_res_o(md_res), .md_res_valid_o(md_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [2:0] ref_alu(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'b01) return 3'b110;
        if (op != 2'b10) return 3'b010;
        if (fn == 6'b100010) return 3'b110;
        if (fn == 6'b100100) return 3'b000;
        if (fn == 6'b100101) return 3'b001;
        if (fn == 6'b101010) return 3'b111;
        if (fn == MULT || fn == MULTU) return 3'b011;
        return 3'b010;
    endfunction

    function automatic logic is_mul(input logic [1:0] op, input logic [5:0] fn);
        return (op == 2'b10) && (fn == MULT || fn == MULTU);
    endfunction

    function automatic logic [63:0] ref_mul(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        return sgn ? 64'(sa * sb) : ua * ub;
    endfunction

    // Model: m_age = cycles since issue (-1 when no multiply in flight); DONE is age W+1.
    int           m_age = -1;
    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic [63:0]  m_prod = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_age = -1; m_hi = '0; m_lo = '0;
        end else if (kill) begin
            m_age = -1;
        end else if (m_age < 0) begin
            if (valid && is_mul(aluop, funct)) begin
                m_age  = 1;
                m_prod = ref_mul(funct == MULT, rs, rt);
            end
        end else if (m_age == W) begin
            {m_hi, m_lo} = m_prod;
            m_age = W + 1;
        end else if (m_age == W + 1) begin
            m_age = -1;
        end else begin
            m_age++;
        end
    end

    always @(negedge clk) begin
        logic e_issue, e_rd, e_mv;
        logic [W-1:0] e_res;
        e_issue = !rst && !kill && (m_age < 0) && valid && is_mul(aluop, funct);
        e_rd    = !rst && valid && (aluop == 2'b10) && ((m_age < 0) || (m_age == W + 1));
        e_mv    = e_rd && (funct == MFHI || funct == MFLO);
        e_res   = !e_mv ? '0 : (funct == MFHI ? m_hi : m_lo);
        chk("m_alu", 64'(alu_ctrl), 64'(ref_alu(aluop, funct)));
        chk("m_stall", 64'(stall), 64'(!rst && !kill && (e_issue || (m_age >= 1 && m_age <= W))));
        chk("m_done", 64'(done), 64'(!rst && !kill && (m_age == W + 1)));
        chk("m_md_valid", 64'(md_valid), 64'(e_mv));
        chk("m_md_res", 64'(md_res), 64'(e_res));
    end

    task automatic drive(input logic v, input logic k, input logic [1:0] op, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        valid = v; kill = k; aluop = op; funct = fn; rs = a; rt = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hilo(input string name, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        drive(1, 0, 2'b10, MFLO, '0, '0);
        @(negedge clk);
        chk({name, "_lo"}, 64'(md_res), 64'(elo));
        chk({name, "_lo_v"}, 64'(md_valid), 64'(1));
        step();
        drive(1, 0, 2'b10, MFHI, '0, '0);
        @(negedge clk);
        chk({name, "_hi"}, 64'(md_res), 64'(ehi));
        step();
        drive(0, 0, 2'b00, '0, '0, '0);
    endtask

    // Operands are held (valid stays high) through DONE, then mflo follows immediately.
    task automatic run_mult(input string name, input logic [5:0] fn, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int stalls = 0, done_at = -1, ndone = 0;
        drive(1, 0, 2'b10, fn, a, b);
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = k;
            end
            step();
            if (done_at >= 0) break;
        end
        chk({name, "_stall_cycles"}, 64'(stalls), 64'(W + 1));
        chk({name, "_done_cycle"}, 64'(done_at), 64'(W + 1));
        chk({name, "_done_pulses"}, 64'(ndone), 64'(1));
        read_hilo(name, ehi, elo);
    endtask

    logic [1:0] sw_op [16] = '{2, 2, 2, 2, 2, 2, 2, 0, 0, 1, 1, 3, 3, 2, 2, 2};
    logic [5:0] sw_fn [16] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h18, 6'h19, 6'h3f,
                               6'h20, 6'h00, 6'h22, 6'h20, 6'h18, 6'h10, 6'h12, 6'h3f};
    logic [2:0] sw_ex [16] = '{2, 6, 0, 1, 7, 3, 3, 2, 2, 6, 6, 2, 2, 2, 2, 2};

    initial begin
        int ndone;
        rst = 1'b1;
        drive(1, 0, 2'b10, MULT, 32'd3, 32'd4);
        repeat (2) step();
        @(negedge clk);
        chk("rst_stall", 64'(stall), 64'(0));
        chk("rst_md_valid", 64'(md_valid), 64'(0));
        step();
        rst = 1'b0;
        read_hilo("reset", 32'h0, 32'h0);

        for (int i = 0; i < 16; i++) begin
            drive(0, 0, sw_op[i], sw_fn[i], '0, '0);
            @(negedge clk);
            chk($sformatf("alu_sweep%0d", i), 64'(alu_ctrl), 64'(sw_ex[i]));
            step();
        end

        run_mult("mult_7_m3", MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_mult("multu_max_2", MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
        run_mult("mult_minneg", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);

        drive(1, 0, 2'b10, MULT, 32'd5, 32'd6);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            step();
        end
        kill = 1'b1;
        @(negedge clk);
        chk("kill_stall", 64'(stall), 64'(0));
        chk("kill_done", 64'(done), 64'(0));
        step();
        drive(0, 0, 2'b00, '0, '0, '0);
        @(negedge clk);
        chk("kill_idle_stall", 64'(stall), 64'(0));
        step();
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) ndone++;
            step();
        end
        chk("kill_no_done", 64'(ndone), 64'(0));
        read_hilo("kill_keep", 32'h4000_0000, 32'h0);

        drive(1, 0, 2'b10, MULTU, 32'd9, 32'd9);
        repeat (5) step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy_stall", 64'(stall), 64'(0));
        step();
        rst = 1'b0;
        drive(0, 0, 2'b00, '0, '0, '0);
        @(negedge clk);
        chk("rst_busy_after", 64'(stall), 64'(0));
        step();
        read_hilo("rst_busy", 32'h0, 32'h0);

        for (int c = 0; c < 3000; c++) begin
            logic [W-1:0] ops [2];
            int r;
            for (int j = 0; j < 2; j++) begin
                case ($urandom_range(0, 5))
                    0: ops[j] = 32'h0;
                    1: ops[j] = 32'h1;
                    2: ops[j] = 32'h8000_0000;
                    3: ops[j] = 32'hFFFF_FFFF;
                    default: ops[j] = $urandom;
                endcase
            end
            rst   = ($urandom_range(0, 299) == 0);
            kill  = ($urandom_range(0, 39) == 0);
            valid = ($urandom_range(0, 3) != 0);
            aluop = ($urandom_range(0, 3) < 2) ? 2'($urandom_range(0, 3)) : 2'b10;
            r = $urandom_range(0, 7);
            case (r)
                0: funct = MULT;
                1: funct = MULTU;
                2: funct = MFHI;
                3: funct = MFLO;
                4: funct = 6'b100010;
                5: funct = 6'b101010;
                default: funct = 6'($urandom_range(0, 63));
            endcase
            rs = ops[0];
            rt = ops[1];
            step();
        end
        rst = 1'b0;
        drive(0, 0, 2'b00, '0, '0, '0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_md.md
ALU_CTRL_MD -- requirements
Module: alu_ctrl_md

Parameters
REQ-001 SHALL provide DATA_W, default 32, operand and HI/LO width (legal 8..64, even).
REQ-002 SHALL provide CNT_W, default $clog2(DATA_W)+1, iteration counter width.

Interface
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 valid_i  input  1  EX-stage instruction valid.
REQ-006 kill_i  input  1  pipeline flush; aborts any multiply in progress.
REQ-007 ALUOp_i  input  2  main-decoder ALU operation class.
REQ-008 funct_i  input  6  R-type function field.
REQ-009 rs_i  input  DATA_W  first operand.
REQ-010 rt_i  input  DATA_W  second operand.
REQ-011 ALUCtrl_o  output  3  ALU control code, combinational.
REQ-012 stall_o  output  1  hold pipeline upstream of EX.
REQ-013 done_o  output  1  one-cycle pulse, multiply result committed.
REQ-014 md_res_o  output  DATA_W  HI or LO read data (mfhi/mflo).
REQ-015 md_res_valid_o  output  1  md_res_o meaningful this cycle.

Function
REQ-016 ALUCtrl_o SHALL decode {ALUOp_i,funct_i}: 10/100000->010, 10/100010->110, 10/100100->000, 10/100101->001, 10/101010->111, 10/011000 or 10/011001->011, 00/any->010, 01/any->110, all others->010.
REQ-017 SHALL treat funct 011000 as signed mult and 011001 as unsigned multu, both only with ALUOp_i=10.
REQ-018 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-019 IDLE, valid_i=1, mult/multu decoded, kill_i=0: stall_o=1 combinationally; at edge latch operand magnitudes (absolute values for mult, raw for multu), latch result sign = sign(rs) XOR sign(rt) for mult (0 for multu), clear 2*DATA_W accumulator, cnt=0, go BUSY.
REQ-020 BUSY: stall_o=1; each edge performs one shift-add step (one multiplier bit), cnt++.
REQ-021 BUSY with cnt=DATA_W-1: at edge write {HI,LO} = accumulator result, two's-complement negated if result sign=1; go DONE.
REQ-022 DONE: stall_o=0, done_o=1; next edge go IDLE unconditionally; the still-present mult in valid_i SHALL NOT re-issue.
REQ-023 Latency: issue cycle 0; BUSY cycles 1..DATA_W; DONE cycle DATA_W+1; total stall_o-high cycles = DATA_W+1.
REQ-024 kill_i=1 in any state: stall_o=0 that cycle, next state IDLE, HI/LO unchanged, done_o=0; kill_i in IDLE blocks issue.
REQ-025 mfhi (10/010000) or mflo (10/010010) with valid_i=1 in IDLE: md_res_o=HI or LO respectively, md_res_valid_o=1, combinational; otherwise md_res_valid_o=0, md_res_o=0.
REQ-026 mfhi/mflo in DONE cycle SHALL return the newly committed HI/LO.
REQ-027 ALUCtrl_o SHALL follow inputs in all states, independent of FSM.
REQ-028 Most-negative operand (e.g. 0x80000000) SHALL multiply correctly via DATA_W-bit unsigned magnitude.

Reset
REQ-029 rst_i=1 at edge: state IDLE, cnt=0, HI=0, LO=0, accumulator=0; overrides kill_i and issue.
REQ-030 During and after reset cycle: stall_o=0, done_o=0, md_res_valid_o=0; reset mid-BUSY discards operation.

Verification (DATA_W=32)
REQ-031 Reset then mfhi,mflo -> md_res_o=0x00000000 both, stall_o=0.
REQ-032 Sweep REQ-016 table incl. ALUOp 11 and unlisted funct -> exact codes, default 010.
REQ-033 mult rs=7, rt=0xFFFFFFFD -> stall_o high 33 cycles, done_o at cycle 33, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-034 multu rs=0xFFFFFFFF, rt=2 -> HI=0x00000001, LO=0xFFFFFFFE; mult 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
REQ-035 Issue mult, kill_i at cycle 10 -> stall_o=0 cycle 10, IDLE cycle 11, HI/LO keep prior values, no done_o.
REQ-036 mult with valid_i held through DONE, then mflo next cycle -> single done_o pulse, no re-issue, md_res_o=new LO.
